digit_scan_ctrl: RTL and testbench



---
 rtl/disp_pkg.sv | 14 +
 rtl/digit_scan_ctrl_if.sv | 40 ++++
 rtl/digit_mux_n.sv | 25 ++
 rtl/digit_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_digit_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// disp_pkg -- shared constants and helpers for the display scan path.
//   AN_OFF              : level that turns an anode off (anodes are active-low)
//   DEFAULT_REFRESH_DIV : default clk cycles each digit stays lit
//   idx_width(n)        : width of an index over n positions, never below 1
package disp_pkg;

  localparam logic AN_OFF              = 1'b1;
  localparam int   DEFAULT_REFRESH_DIV = 100000;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if -- bundle between the number formatter, the scan
// controller and the segment decoder.
//   master : drives data_in / load / digit_en, observes the scan outputs
//   slave  : the scan controller
// Signals:
//   data_in    packed digits, digit i at [i*DIGIT_W +: DIGIT_W]
//   load       one-cycle strobe, capture data_in into the shadow register
//   digit_en   per-position enable, 0 keeps that anode dark
//   an         active-low anode drive, one-cold or all ones
//   digit_out  value of the currently scanned digit
//   digit_idx  currently scanned position
//   pending    shadow holds data not yet committed
//   frame_done one-cycle pulse when the scan wraps to position 0
interface digit_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);

  localparam int IDX_W = disp_pkg::idx_width(NUM_DIGITS);

  logic [NUM_DIGITS*DIGIT_W-1:0] data_in;
  logic                          load;
  logic [NUM_DIGITS-1:0]         digit_en;
  logic [NUM_DIGITS-1:0]         an;
  logic [DIGIT_W-1:0]            digit_out;
  logic [IDX_W-1:0]              digit_idx;
  logic                          pending;
  logic                          frame_done;

  modport master (
    output data_in, load, digit_en,
    input  an, digit_out, digit_idx, pending, frame_done
  );

  modport slave (
    input  data_in, load, digit_en,
    output an, digit_out, digit_idx, pending, frame_done
  );

endinterface

// File: rtl/digit_mux_n.sv
// digit_mux_n -- combinational NUM_DIGITS-to-1 selector of DIGIT_W-bit
// fields out of a packed digit vector.
//   i_data  : packed digits, digit i at [i*DIGIT_W +: DIGIT_W]
//   i_sel   : position to select
//   o_digit : selected digit (0 if i_sel is out of range)
module digit_mux_n #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_data,
  input  logic [IDX_W-1:0]              i_sel,
  output logic [DIGIT_W-1:0]            o_digit
);

  // NOTE: o_digit gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i_sel == IDX_W'(i)) o_digit = i_data[i*DIGIT_W +: DIGIT_W];
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl -- self-timed, tear-free multiplexed scan of NUM_DIGITS
// digits onto a shared digit bus with matching active-low anode drive.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : digit_scan_ctrl_if.slave (data_in/load/digit_en in,
//         an/digit_out/digit_idx/pending/frame_done out)
// New digits are loaded into a shadow register and only copied to the
// displayed (active) register when the scan lands on position 0, so a frame
// never shows a mix of old and new digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken positions above
// the most significant nonzero committed digit (position 0 always shown).
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic             clk,
  input  logic             rst,
  digit_scan_ctrl_if.slave bus
);

  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int CNT_W  = idx_width(REFRESH_DIV);
  localparam int DATA_W = NUM_DIGITS * DIGIT_W;

  logic [CNT_W-1:0]      r_cnt;
  logic                  r_run;        // first tick after reset has happened
  logic [IDX_W-1:0]      r_idx;
  logic [DIGIT_W-1:0]    r_digit;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;
  logic [DATA_W-1:0]     r_shadow;
  logic [DATA_W-1:0]     r_active;
  logic                  r_pending;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_idx_next;
  logic [DATA_W-1:0]     w_active_next;
  logic [DIGIT_W-1:0]    w_digit_next;
  logic [NUM_DIGITS-1:0] w_keep;       // positions allowed to light
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_tick = (r_cnt == CNT_W'(REFRESH_DIV - 1));

  // Out of reset the scan sits dark on position 0; its first tick lights
  // position 0 rather than advancing, so every frame starts at 0.
  assign w_idx_next = (!r_run || r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                   : r_idx + IDX_W'(1);

  assign w_wrap   = w_tick && (w_idx_next == '0);
  assign w_commit = w_wrap && r_pending;

  // Digit 0 of a freshly committed frame must show on the commit edge,
  // so the mux and blanking look at the value active will hold next.
  assign w_active_next = w_commit ? r_shadow : r_active;

  digit_mux_n #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .IDX_W      (IDX_W)
  ) u_mux (
    .i_data  (w_active_next),
    .i_sel   (w_idx_next),
    .o_digit (w_digit_next)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top down: once a nonzero digit is seen, it and every
  // lower position stay lit.
  always_comb begin : blank_calc
    logic v_seen;
    v_seen = 1'b0;
    w_keep = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (w_active_next[i*DIGIT_W +: DIGIT_W] != '0) v_seen = 1'b1;
      w_keep[i] = v_seen;
    end
    w_keep[0] = 1'b1;
  end
`else
  assign w_keep = '1;
`endif

  always_comb begin
    w_an_next = {NUM_DIGITS{AN_OFF}};
    if (bus.digit_en[w_idx_next] && w_keep[w_idx_next]) w_an_next[w_idx_next] = ~AN_OFF;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // sees the pre-edge value of the others, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_run        <= 1'b0;
      r_idx        <= '0;
      r_digit      <= '0;
      r_an         <= {NUM_DIGITS{AN_OFF}};
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_cnt   <= '0;
        r_run   <= 1'b1;
        r_idx   <= w_idx_next;
        r_digit <= w_digit_next;
        r_an    <= w_an_next;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: shadow and active are a handful of flops, not a RAM, so they
  // take the reset like any other register and display zeros after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_commit) r_active <= r_shadow;
      if (bus.load) r_shadow <= bus.data_in;
      // A load on the commit edge re-arms pending for the following frame.
      r_pending <= bus.load || (r_pending && !w_wrap);
    end
  end

  assign bus.an         = r_an;
  assign bus.digit_out  = r_digit;
  assign bus.digit_idx  = r_idx;
  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl -- self-checking bench for digit_scan_ctrl.
// Two instances: 4 digits with a 4-cycle dwell, and 6 digits with a 1-cycle
// dwell. A timeline model (edges counted since reset release, shadow/active
// tracked as plain values) is compared with both instances every cycle;
// directed sections pin the model with hand-computed literal values.
module tb_digit_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1;
  logic rst6 = 1'b1;

  digit_scan_ctrl_if #(.NUM_DIGITS(4), .DIGIT_W(4)) if4 ();
  digit_scan_ctrl_if #(.NUM_DIGITS(6), .DIGIT_W(4)) if6 ();

  digit_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_W(4), .REFRESH_DIV(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4.slave)
  );

  digit_scan_ctrl #(.NUM_DIGITS(6), .DIGIT_W(4), .REFRESH_DIV(1)) dut6 (
    .clk (clk),
    .rst (rst6),
    .bus (if6.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cyc  [2];
  logic [23:0] m_sh   [2];
  logic [23:0] m_act  [2];
  bit          m_pend [2];
  logic [2:0]  e_idx  [2];
  logic [5:0]  e_an   [2];
  logic [3:0]  e_dig  [2];
  bit          e_pend [2];
  bit          e_fd   [2];

  // Position k (0,1,2,...) since release is lit at edge (k+1)*rd; position
  // index is k mod n, and landing on index 0 starts a frame.
  task automatic model_step(input int m, input int n, input int rd, input logic r,
                            input logic ld, input logic [23:0] data, input logic [5:0] en);
    int  idx;
    int  msd;
    bit  tick;
    if (r) begin
      m_cyc[m]  = 0;
      m_sh[m]   = '0;
      m_act[m]  = '0;
      m_pend[m] = 0;
      e_idx[m]  = '0;
      e_an[m]   = 6'h3F >> (6 - n);
      e_dig[m]  = '0;
      e_pend[m] = 0;
      e_fd[m]   = 0;
    end else begin
      m_cyc[m]++;
      tick    = (m_cyc[m] % rd) == 0;
      idx     = (m_cyc[m] / rd - 1) % n;
      e_fd[m] = tick && (idx == 0);
      if (e_fd[m] && m_pend[m]) begin
        m_act[m]  = m_sh[m];
        m_pend[m] = 0;
      end
      if (ld) begin
        m_sh[m]   = data;
        m_pend[m] = 1;
      end
      e_pend[m] = m_pend[m];
      if (tick) begin
        msd = n - 1;
`ifdef LEADING_ZERO_BLANK_EN
        msd = 0;
        for (int i = 0; i < n; i++) if (m_act[m][4*i +: 4] != 4'h0) msd = i;
`endif
        e_idx[m] = 3'(idx);
        e_dig[m] = m_act[m][4*idx +: 4];
        e_an[m]  = 6'h3F >> (6 - n);
        if (en[idx] && idx <= msd) e_an[m][idx] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4, 4, rst4, if4.load, {8'h00, if4.data_in}, {2'b00, if4.digit_en});
    model_step(1, 6, 1, rst6, if6.load, if6.data_in, if6.digit_en);
    #1;
    check("m4_idx",  32'(if4.digit_idx),  32'(e_idx[0]));
    check("m4_an",   32'(if4.an),         32'(e_an[0]));
    check("m4_dig",  32'(if4.digit_out),  32'(e_dig[0]));
    check("m4_pend", 32'(if4.pending),    32'(e_pend[0]));
    check("m4_fd",   32'(if4.frame_done), 32'(e_fd[0]));
    check("m6_idx",  32'(if6.digit_idx),  32'(e_idx[1]));
    check("m6_an",   32'(if6.an),         32'(e_an[1]));
    check("m6_dig",  32'(if6.digit_out),  32'(e_dig[1]));
    check("m6_pend", 32'(if6.pending),    32'(e_pend[1]));
    check("m6_fd",   32'(if6.frame_done), 32'(e_fd[1]));
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fd4(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = if4.frame_done;
    end
    check("fd4_seen", 32'(seen), 32'd1);
  endtask

  task automatic load4(input logic [15:0] d);
    if4.load    = 1'b1;
    if4.data_in = d;
    @(negedge clk);
    if4.load    = 1'b0;
  endtask

  logic [3:0] an_exp  [4];
  logic [3:0] dig_exp [4];

  initial begin
    if4.load = 1'b0; if4.data_in = '0; if4.digit_en = 4'hF;
    if6.load = 1'b0; if6.data_in = '0; if6.digit_en = 6'h3F;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_an4",   32'(if4.an),        32'hF);
    check("rst_dig4",  32'(if4.digit_out), 32'h0);
    check("rst_pend4", 32'(if4.pending),   32'h0);
    rst4 = 1'b0;

    // First tick lights position 0; then 1,2,3,0 every 4 cycles
    wait_fd4(20);
    check("first_idx", 32'(if4.digit_idx), 32'd0);
    check("first_an",  32'(if4.an),        32'hE);
    for (int j = 1; j <= 4; j++) begin
      repeat (4) @(negedge clk);
      check("scan_idx", 32'(if4.digit_idx),  32'(j % 4));
      check("scan_fd",  32'(if4.frame_done), 32'(j == 4));
    end

    // Mid-frame load, committed at the wrap
    repeat (5) @(negedge clk);
    load4(16'h1234);
    check("pend_set", 32'(if4.pending), 32'd1);
    wait_fd4(20);
    check("c1234_d0",  32'(if4.digit_out), 32'h4);
    check("c1234_pnd", 32'(if4.pending),   32'd0);
    for (int j = 1; j < 4; j++) begin
      repeat (4) @(negedge clk);
      check("c1234_dn", 32'(if4.digit_out), 32'(4 - j));
    end

    // Two loads before the wrap: the latest wins
    load4(16'hAAAA);
    load4(16'h5555);
    wait_fd4(20);
    check("latest_d0", 32'(if4.digit_out), 32'h5);
    for (int j = 1; j < 4; j++) begin
      repeat (4) @(negedge clk);
      check("latest_dn", 32'(if4.digit_out), 32'h5);
    end

    // Load on the wrap edge: old shadow commits, new one waits a frame
    load4(16'h9876);
    repeat (2) @(negedge clk);
    load4(16'h4321);
    check("coin_fd",   32'(if4.frame_done), 32'd1);
    check("coin_dig",  32'(if4.digit_out),  32'h6);
    check("coin_pend", 32'(if4.pending),    32'd1);
    wait_fd4(20);
    check("coin_next", 32'(if4.digit_out), 32'h1);
    check("coin_pnd0", 32'(if4.pending),   32'd0);

    // Enable mask 0101 across one frame
    if4.digit_en = 4'b0101;
    an_exp = '{4'hE, 4'hF, 4'hB, 4'hF};
    wait_fd4(20);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) repeat (4) @(negedge clk);
      check("en_an", 32'(if4.an), 32'(an_exp[j]));
    end
    if4.digit_en = 4'hF;

    // Leading-zero data 0070, then all zeros
    load4(16'h0070);
`ifdef LEADING_ZERO_BLANK_EN
    an_exp = '{4'hE, 4'hD, 4'hF, 4'hF};
`else
    an_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
    dig_exp = '{4'h0, 4'h7, 4'h0, 4'h0};
    wait_fd4(20);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) repeat (4) @(negedge clk);
      check("lz70_an",  32'(if4.an),        32'(an_exp[j]));
      check("lz70_dig", 32'(if4.digit_out), 32'(dig_exp[j]));
    end
    load4(16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
    an_exp = '{4'hE, 4'hF, 4'hF, 4'hF};
`else
    an_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
    wait_fd4(20);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) repeat (4) @(negedge clk);
      check("lz00_an", 32'(if4.an), 32'(an_exp[j]));
    end

    // Six digits, one-cycle dwell
    rst6 = 1'b0;
    @(negedge clk);
    check("d6_first_fd",  32'(if6.frame_done), 32'd1);
    check("d6_first_an",  32'(if6.an),         32'h3E);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("d6_idx", 32'(if6.digit_idx),  32'(j % 6));
      check("d6_fd",  32'(if6.frame_done), 32'(j == 6));
    end
    begin
      bit at3;
      at3 = 0;
      for (int i = 0; i < 12 && !at3; i++) begin
        @(negedge clk);
        at3 = (if6.digit_idx == 3'd3);
      end
      check("d6_reach3", 32'(at3), 32'd1);
    end
    rst6 = 1'b1;
    #1;
    check("d6_rst_idx", 32'(if6.digit_idx), 32'd0);
    check("d6_rst_an",  32'(if6.an),        32'h3F);
    @(negedge clk);
    rst6 = 1'b0;
    @(negedge clk);
    check("d6_rel_idx", 32'(if6.digit_idx), 32'd0);
    check("d6_rel_an",  32'(if6.an),        32'h3E);

    // Randomized traffic on both instances, checked by the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if4.load    = ($urandom_range(0, 7) == 0);
      if4.data_in = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) if4.digit_en = 4'($urandom);
      if6.load    = ($urandom_range(0, 5) == 0);
      if6.data_in = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
      if ($urandom_range(0, 31) == 0) if6.digit_en = 6'($urandom);
      if (c == 300) rst4 = 1'b1;
      if (c == 302) rst4 = 1'b0;
      if (c == 450) rst6 = 1'b1;
      if (c == 451) rst6 = 1'b0;
    end
    if4.load = 1'b0;
    if6.load = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
